tb_commit_scoreboard: RTL and testbench

- Lockstep retirement checker for the CPU testbench.
- The DUT retires up to NCH instructions per cycle; retirements are buffered in a FIFO and popped one per handshake against a reference-model (ISS) stream.
- Compares PC and, optionally, register writeback. Detects tohost exit, FIFO overflow and a commit-free watchdog timeout.
- Latches a sticky pass/fail verdict for the testbench top to report and $finish on.

---
 rtl/tb_commit_scoreboard_if.sv | 40 ++++
 rtl/tb_commit_scoreboard.sv | 165 ++++++++++++++++
 tb/tb_tb_commit_scoreboard.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/tb_commit_scoreboard_if.sv
// Retirement-checker bus: DUT commit lanes, reference-model stream, tohost and verdict.
// The scoreboard takes the slave modport; the driving bench takes the master modport.
interface tb_commit_scoreboard_if #(
    parameter int XLEN = 32,
    parameter int NCH  = 2,
    parameter int CNTW = 32
);
    logic [NCH-1:0]      DUT_VALID;
    logic [NCH*XLEN-1:0] DUT_PC;
    logic [NCH*5-1:0]    DUT_RD;
    logic [NCH-1:0]      DUT_WE;
    logic [NCH*XLEN-1:0] DUT_WDATA;
    logic                REF_VALID;
    logic                REF_READY;
    logic [XLEN-1:0]     REF_PC;
    logic [4:0]          REF_RD;
    logic                REF_WE;
    logic [XLEN-1:0]     REF_WDATA;
    logic                TOHOST_WE;
    logic [31:0]         TOHOST;
    logic                DONE;
    logic                PASS;
    logic [2:0]          FAIL_CODE;
    logic [XLEN-1:0]     FAIL_PC;
    logic [CNTW-1:0]     COMMIT_CNT;

    modport master (
        output DUT_VALID, DUT_PC, DUT_RD, DUT_WE, DUT_WDATA,
        output REF_VALID, REF_PC, REF_RD, REF_WE, REF_WDATA,
        output TOHOST_WE, TOHOST,
        input  REF_READY, DONE, PASS, FAIL_CODE, FAIL_PC, COMMIT_CNT
    );

    modport slave (
        input  DUT_VALID, DUT_PC, DUT_RD, DUT_WE, DUT_WDATA,
        input  REF_VALID, REF_PC, REF_RD, REF_WE, REF_WDATA,
        input  TOHOST_WE, TOHOST,
        output REF_READY, DONE, PASS, FAIL_CODE, FAIL_PC, COMMIT_CNT
    );
endinterface

// File: rtl/tb_commit_scoreboard.sv
// Lockstep retirement checker: buffers DUT commits, compares against the ISS stream, latches a verdict.
// Define SCB_CHECK_WDATA_EN to also compare register writeback (WE/RD/WDATA).
module tb_commit_scoreboard #(
    parameter int XLEN    = 32,
    parameter int NCH     = 2,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4096,
    parameter int CNTW    = 32
) (
    input logic                   CLK,
    input logic                   RSTn,
    tb_commit_scoreboard_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CB = AW + 1;
    localparam int SB = AW + 2;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_PASS, ST_FAIL} state_t;

`ifdef SCB_CHECK_WDATA_EN
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic            we;
        logic [XLEN-1:0] wdata;
    } entry_t;
`else
    typedef struct packed {
        logic [XLEN-1:0] pc;
    } entry_t;
`endif

    state_t          state;
    entry_t          mem [DEPTH];
    entry_t          lane_entry [NCH];
    logic [AW-1:0]   lane_idx [NCH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CB-1:0]   count;
    logic [SB-1:0]   push_cnt, occ;
    logic [WW-1:0]   wdog;
    logic [31:0]     tohost_q;
    logic            done_q, pass_q;
    logic [2:0]      fail_code_q;
    logic [XLEN-1:0] fail_pc_q;
    logic [CNTW-1:0] commit_cnt_q;
    logic            active, ref_ready, pop, overflow, idle;
    logic            pc_mismatch, wb_mismatch;
    entry_t          head;

    assign active    = (state == ST_RUN) || (state == ST_DRAIN);
    assign ref_ready = active && (count != '0);
    assign pop       = ref_ready && bus.REF_VALID;
    assign head      = mem[rd_ptr];

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            lane_entry[i].pc = bus.DUT_PC[i*XLEN +: XLEN];
`ifdef SCB_CHECK_WDATA_EN
            lane_entry[i].rd    = bus.DUT_RD[i*5 +: 5];
            lane_entry[i].we    = bus.DUT_WE[i];
            lane_entry[i].wdata = bus.DUT_WDATA[i*XLEN +: XLEN];
`endif
        end
    end

    // Compaction: each valid lane lands at wr_ptr + (number of valid lanes below it).
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            lane_idx[i] = wr_ptr + push_cnt[AW-1:0];
            if (active && bus.DUT_VALID[i]) push_cnt = push_cnt + SB'(1);
        end
    end

    assign occ      = SB'(count) + push_cnt - SB'(pop);
    assign overflow = occ > SB'(DEPTH);
    assign idle     = (push_cnt == '0) && !pop;

    assign pc_mismatch = head.pc != bus.REF_PC;

`ifdef SCB_CHECK_WDATA_EN
    logic dut_we_eff, ref_we_eff;
    // A write to x0 is architecturally invisible, so it compares as no write.
    assign dut_we_eff  = head.we && (head.rd != 5'd0);
    assign ref_we_eff  = bus.REF_WE && (bus.REF_RD != 5'd0);
    assign wb_mismatch = (dut_we_eff != ref_we_eff) ||
                         (ref_we_eff && ((head.rd != bus.REF_RD) || (head.wdata != bus.REF_WDATA)));
`else
    logic unused_wb;
    assign wb_mismatch = 1'b0;
    assign unused_wb   = ^{bus.DUT_RD, bus.DUT_WE, bus.DUT_WDATA, bus.REF_RD, bus.REF_WE, bus.REF_WDATA};
`endif

    // NOTE: FIFO storage is deliberately not reset; count/pointers alone decide what is valid.
    always_ff @(posedge CLK) begin
        if (!overflow) begin
            for (int i = 0; i < NCH; i++) begin
                if (active && bus.DUT_VALID[i]) mem[lane_idx[i]] <= lane_entry[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state        <= ST_RUN;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            wdog         <= '0;
            tohost_q     <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_code_q  <= 3'd0;
            fail_pc_q    <= '0;
            commit_cnt_q <= '0;
        end else if (active) begin
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (!overflow) begin
                wr_ptr <= wr_ptr + push_cnt[AW-1:0];
                count  <= occ[CB-1:0];
            end else begin
                count  <= count - CB'(pop);
            end
            if (!idle)                 wdog <= '0;
            else if (wdog != WW'(TIMEOUT)) wdog <= wdog + WW'(1);
            if (pop && !pc_mismatch && !wb_mismatch) commit_cnt_q <= commit_cnt_q + CNTW'(1);
            if (state == ST_RUN && bus.TOHOST_WE) begin
                tohost_q <= bus.TOHOST;
                state    <= ST_DRAIN;
            end
            // Later branches lose: overflow > compare > tohost verdict > timeout.
            if (overflow) begin
                state       <= ST_FAIL;
                done_q      <= 1'b1;
                fail_code_q <= 3'd3;
            end else if (pop && (pc_mismatch || wb_mismatch)) begin
                state       <= ST_FAIL;
                done_q      <= 1'b1;
                fail_code_q <= pc_mismatch ? 3'd1 : 3'd2;
                fail_pc_q   <= bus.REF_PC;
            end else if (state == ST_DRAIN && count == '0 && push_cnt == '0) begin
                done_q <= 1'b1;
                if (tohost_q == 32'd1) begin
                    state  <= ST_PASS;
                    pass_q <= 1'b1;
                end else begin
                    state       <= ST_FAIL;
                    fail_code_q <= 3'd5;
                end
            end else if (idle && wdog == WW'(TIMEOUT - 1)) begin
                state       <= ST_FAIL;
                done_q      <= 1'b1;
                fail_code_q <= 3'd4;
            end
        end
    end

    assign bus.REF_READY  = ref_ready;
    assign bus.DONE       = done_q;
    assign bus.PASS       = pass_q;
    assign bus.FAIL_CODE  = fail_code_q;
    assign bus.FAIL_PC    = fail_pc_q;
    assign bus.COMMIT_CNT = commit_cnt_q;
endmodule

// File: tb/tb_tb_commit_scoreboard.sv
// Directed bench for tb_commit_scoreboard: table of push/pop vectors plus hand-written
// overflow, drain, tohost, timeout, writeback and async-reset sequences (TIMEOUT = 16).
module tb_tb_commit_scoreboard;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    tb_commit_scoreboard_if #(.XLEN(32), .NCH(2), .CNTW(32)) bus ();

    tb_commit_scoreboard #(
        .XLEN(32), .NCH(2), .DEPTH(8), .TIMEOUT(16), .CNTW(32)
    ) dut (
        .CLK(clk),
        .RSTn(rst_n),
        .bus(bus.slave)
    );

    typedef struct {
        string       name;
        logic [1:0]  valid;
        logic [31:0] pc0, pc1;
        logic [31:0] ref0, ref1;
        int          pops;
        logic        done;
        logic [2:0]  code;
        logic [31:0] fpc;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.DUT_VALID = '0;
        bus.DUT_PC    = '0;
        bus.DUT_RD    = '0;
        bus.DUT_WE    = '0;
        bus.DUT_WDATA = '0;
        bus.REF_VALID = 1'b0;
        bus.REF_PC    = '0;
        bus.REF_RD    = '0;
        bus.REF_WE    = 1'b0;
        bus.REF_WDATA = '0;
        bus.TOHOST_WE = 1'b0;
        bus.TOHOST    = '0;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_verdict(input string tag, input logic done, input logic pass,
                                 input logic [2:0] code, input logic [31:0] fpc,
                                 input logic [31:0] cnt);
        check({tag, ".done"}, 64'(bus.DONE), 64'(done));
        check({tag, ".pass"}, 64'(bus.PASS), 64'(pass));
        check({tag, ".code"}, 64'(bus.FAIL_CODE), 64'(code));
        check({tag, ".fail_pc"}, 64'(bus.FAIL_PC), 64'(fpc));
        check({tag, ".cnt"}, 64'(bus.COMMIT_CNT), 64'(cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required $finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        vecs[0] = '{"burst2",    2'b11, 32'h100,  32'h104, 32'h100, 32'h104, 2, 1'b0, 3'd0, 32'h0,   32'd2};
        vecs[1] = '{"pc_mis",    2'b01, 32'h200,  32'h0,   32'h204, 32'h0,   1, 1'b1, 3'd1, 32'h204, 32'd0};
        vecs[2] = '{"lane1only", 2'b10, 32'hdead, 32'h300, 32'h300, 32'h0,   1, 1'b0, 3'd0, 32'h0,   32'd1};
        vecs[3] = '{"second_mis",2'b11, 32'h400,  32'h404, 32'h400, 32'h408, 2, 1'b1, 3'd1, 32'h408, 32'd1};
        vecs[4] = '{"first_mis", 2'b11, 32'h500,  32'h504, 32'h504, 32'h504, 2, 1'b1, 3'd1, 32'h504, 32'd0};
        vecs[5] = '{"empty_pop", 2'b00, 32'h0,    32'h0,   32'h0,   32'h0,   1, 1'b0, 3'd0, 32'h0,   32'd0};

        idle_inputs();
        tick();
        tick();
        check_verdict("reset", 1'b0, 1'b0, 3'd0, 32'h0, 32'd0);
        check("reset.ref_ready", 64'(bus.REF_READY), 64'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            do_reset();
            bus.DUT_VALID = vecs[v].valid;
            bus.DUT_PC    = {vecs[v].pc1, vecs[v].pc0};
            check({vecs[v].name, ".ready_c0"}, 64'(bus.REF_READY), 64'd0);
            tick();
            bus.DUT_VALID = '0;
            for (int k = 0; k < vecs[v].pops; k++) begin
                bus.REF_VALID = 1'b1;
                bus.REF_PC    = (k == 0) ? vecs[v].ref0 : vecs[v].ref1;
                tick();
            end
            bus.REF_VALID = 1'b0;
            check_verdict(vecs[v].name, vecs[v].done, 1'b0, vecs[v].code, vecs[v].fpc, vecs[v].cnt);
        end

        // Overflow: 2 lanes per cycle, no pops; the 5th push would make 10 > 8.
        do_reset();
        bus.DUT_VALID = 2'b11;
        for (int c = 0; c < 4; c++) tick();
        check("ovf.done_before", 64'(bus.DONE), 64'd0);
        tick();
        bus.DUT_VALID = '0;
        check_verdict("ovf", 1'b1, 1'b0, 3'd3, 32'h0, 32'd0);

        // Drain pass, with a second tohost write during DRAIN that must be ignored.
        do_reset();
        bus.DUT_VALID = 2'b11;
        bus.DUT_PC    = {32'h14, 32'h10};
        tick();
        bus.DUT_VALID = 2'b01;
        bus.DUT_PC    = {32'h0, 32'h18};
        tick();
        bus.DUT_VALID = '0;
        bus.TOHOST_WE = 1'b1;
        bus.TOHOST    = 32'd1;
        tick();
        bus.TOHOST    = 32'd7;
        bus.REF_VALID = 1'b1;
        bus.REF_PC    = 32'h10;
        tick();
        bus.TOHOST_WE = 1'b0;
        bus.REF_PC    = 32'h14;
        tick();
        bus.REF_PC    = 32'h18;
        tick();
        bus.REF_VALID = 1'b0;
        check("drain.done_before", 64'(bus.DONE), 64'd0);
        tick();
        check_verdict("drain", 1'b1, 1'b1, 3'd0, 32'h0, 32'd3);

        // tohost fail on empty FIFO resolves on the second edge.
        do_reset();
        bus.TOHOST_WE = 1'b1;
        bus.TOHOST    = 32'h0000_0007;
        tick();
        bus.TOHOST_WE = 1'b0;
        check("tohost.done_edge1", 64'(bus.DONE), 64'd0);
        tick();
        check_verdict("tohost", 1'b1, 1'b0, 3'd5, 32'h0, 32'd0);

        // Watchdog: idle from reset release, fires on the 16th edge.
        do_reset();
        for (int c = 0; c < 15; c++) tick();
        check("wdog.done_15", 64'(bus.DONE), 64'd0);
        tick();
        check_verdict("wdog", 1'b1, 1'b0, 3'd4, 32'h0, 32'd0);

        // Writeback: lane0 writes x0 (ref says no write), lane1 wdata differs.
        do_reset();
        bus.DUT_VALID = 2'b11;
        bus.DUT_PC    = {32'h604, 32'h600};
        bus.DUT_RD    = {5'd5, 5'd0};
        bus.DUT_WE    = 2'b11;
        bus.DUT_WDATA = {32'h11, 32'h99};
        tick();
        bus.DUT_VALID = '0;
        bus.REF_VALID = 1'b1;
        bus.REF_PC    = 32'h600;
        bus.REF_WE    = 1'b0;
        tick();
        bus.REF_PC    = 32'h604;
        bus.REF_RD    = 5'd5;
        bus.REF_WE    = 1'b1;
        bus.REF_WDATA = 32'h12;
        tick();
        bus.REF_VALID = 1'b0;
`ifdef SCB_CHECK_WDATA_EN
        check_verdict("wb", 1'b1, 1'b0, 3'd2, 32'h604, 32'd1);
`else
        check_verdict("wb", 1'b0, 1'b0, 3'd0, 32'h0, 32'd2);
`endif
        // Fail the bench state first so the async clear is observable, then reset mid-cycle.
        bus.TOHOST_WE = 1'b1;
        bus.TOHOST    = 32'd3;
        tick();
        bus.TOHOST_WE = 1'b0;
        tick();
        check("pre_rst.done", 64'(bus.DONE), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.done", 64'(bus.DONE), 64'd0);
        check("async_rst.code", 64'(bus.FAIL_CODE), 64'd0);
        check("async_rst.cnt", 64'(bus.COMMIT_CNT), 64'd0);
        tick();
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
